// File: rtl/cobra_core_param.sv
// cobra_core_param: parametrised single-cycle 32-bit-ISA core with switch handshake, output port and HALT.
// Optional build macro COBRA_STALL_CNT_EN adds stall_cnt_o (saturating count of WAIT_IN cycles).
module cobra_core_param #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned PC_W     = 10,
    parameter int unsigned SW_W     = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic [PC_W-1:0] pc_o,
    input  logic [31:0]     instr_i,
    input  logic [SW_W-1:0] sw_i,
    input  logic            sw_valid_i,
    output logic            sw_ready_o,
    output logic [XLEN-1:0] out_o,
    output logic            out_valid_o,
    output logic            halted_o
`ifdef COBRA_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o
`endif
);

    localparam int unsigned SHW = $clog2(XLEN);

    typedef struct packed {
        logic       j;
        logic       b;
        logic [1:0] ws;
        logic [4:0] op;
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic [7:0] off;
        logic [4:0] wa;
    } instr_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    instr_t            ins;
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc, pc_br, off_ext;
    logic [XLEN-1:0]   out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   rf [32];
    logic [XLEN-1:0]   a, b, alu_res, cst, wd;
    logic [SHW-1:0]    shamt;
    logic              flag, we, is_halt, is_in, xfer;

    assign ins     = instr_t'(instr_i);
    assign is_halt = ins.j & ins.b;
    assign is_in   = ~ins.j & (ins.ws == 2'b10);
    assign cst     = XLEN'($signed(instr_i[27:5]));
    assign off_ext = PC_W'($signed(ins.off));
    assign pc_inc  = pc_q + PC_W'(1);
    assign pc_br   = pc_q + off_ext;

    assign a     = rf[ins.ra1];
    assign b     = rf[ins.ra2];
    assign shamt = b[SHW-1:0];

    assign sw_ready_o = ((state_q == ST_RUN) || (state_q == ST_WAIT)) && is_in;
    assign xfer       = sw_ready_o & sw_valid_i;

    // Register file: x0 and addresses beyond REG_NUM are constant zero, so their writes vanish.
    for (genvar g = 0; g < 32; g++) begin : g_rf
        if ((g == 0) || (g >= int'(REG_NUM))) begin : g_zero
            assign rf[g] = '0;
        end else begin : g_reg
            logic [XLEN-1:0] r_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_q <= '0;
                end else if (we && (ins.wa == 5'(g))) begin
                    r_q <= wd;
                end
            end
            assign rf[g] = r_q;
        end
    end

    always_comb begin
        alu_res = '0;
        flag    = 1'b0;
        case (ins.op)
            5'b00000: alu_res = a + b;
            5'b01000: alu_res = a - b;
            5'b00100: alu_res = a ^ b;
            5'b00110: alu_res = a | b;
            5'b00111: alu_res = a & b;
            5'b00001: alu_res = a << shamt;
            5'b00101: alu_res = a >> shamt;
            5'b01101: alu_res = $unsigned($signed(a) >>> shamt);
            5'b00010: alu_res = XLEN'($signed(a) < $signed(b));
            5'b00011: alu_res = XLEN'(a < b);
            5'b11100: flag    = $signed(a) < $signed(b);
            5'b11110: flag    = a < b;
            5'b11101: flag    = $signed(a) >= $signed(b);
            5'b11111: flag    = a >= b;
            5'b11000: flag    = a == b;
            5'b11001: flag    = a != b;
            default: ;
        endcase
    end

    // Next-state, next-PC and writeback decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        we          = 1'b0;
        wd          = '0;
        out_d       = out_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (is_halt) begin
                    state_d = ST_HALT;
                end else if (is_in) begin
                    if (sw_valid_i) begin
                        we   = 1'b1;
                        wd   = XLEN'(sw_i);
                        pc_d = pc_inc;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    pc_d = (ins.j || (ins.b && flag)) ? pc_br : pc_inc;
                    if (ins.ws == 2'b11) begin
                        out_d       = a;
                        out_valid_d = 1'b1;
                    end else if (!ins.j) begin
                        if (ins.ws == 2'b00) begin
                            we = 1'b1;
                            wd = cst;
                        end else if (!ins.b) begin
                            we = 1'b1;
                            wd = alu_res;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (xfer) begin
                    we      = 1'b1;
                    wd      = XLEN'(sw_i);
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            ST_HALT: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            pc_q        <= PC_W'(RESET_PC);
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pc_o        = pc_q;
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign halted_o    = (state_q == ST_HALT);

`ifdef COBRA_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_WAIT) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
